// File: rtl/hop_chain_pkg.sv
// Shared types and elaboration helpers for the hop chain pipe.
package hop_chain_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      FLUSH = 1'b1
   } state_e;

   function automatic int grp_of(input int k, input int depth, input int ngrp);
      return (k * ngrp) / depth;
   endfunction

   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/hop_chain_pipe_stage.sv
// One chain register: {valid, payload} with load enable and async clear.
module hop_stage #(
   parameter int W = 2
) (
   input  logic         clock0,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] q_q;
   logic [W-1:0] q_d;

   always_comb begin
      q_d = en ? d : q_q;
   end

   always_ff @(posedge clock0 or posedge clr) begin
      if (clr) q_q <= '0;
      else     q_q <= q_d;
   end

   assign q = q_q;

endmodule

// File: rtl/hop_chain_pipe.sv
// Multi-reset-domain shift chain with gated output stage,
// sticky overrun flag and a drain-on-request flush FSM.
module hop_chain_pipe
   import hop_chain_pkg::*;
#(
   parameter int WIDTH = 1,
   parameter int DEPTH = 8,
   parameter int NGRP  = 6
) (
   input  logic                          clock0,
   input  logic                          rst1,
   input  logic [NGRP-1:0]               grp_rst,
   input  logic [WIDTH-1:0]              din,
   input  logic                          din_valid,
   input  logic                          adv,
   input  logic                          out_en,
   input  logic                          flush,
   input  logic                          ovf_clr,
   output logic [WIDTH-1:0]              dout,
   output logic                          dout_valid,
   output logic [$clog2(DEPTH+1)-1:0]    fill_cnt,
   output logic                          ovf,
   output logic                          busy
);

   localparam int CW = cnt_w(DEPTH);

   state_e           state_q, state_d;
   logic             ovf_q, ovf_d;
   logic             eff_adv, eff_out_en;
   logic [WIDTH:0]   stg_d [DEPTH];
   logic [WIDTH:0]   stg_q [DEPTH];
   logic [DEPTH-1:0] stg_en;
   logic [DEPTH-1:0] stg_clr;
   logic [DEPTH-1:0] vld;
   logic [CW-1:0]    cnt;

   always_comb begin
      state_d    = state_q;
      eff_adv    = adv;
      eff_out_en = out_en;
      unique case (state_q)
         IDLE: begin
            if (flush) state_d = FLUSH;
         end
         FLUSH: begin
            eff_adv    = 1'b1;
            eff_out_en = 1'b1;
            if (cnt == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Flushing feeds bubbles so the chain empties behind the drain.
   always_comb begin
      stg_d[0] = (state_q == FLUSH) ? '0 : {din_valid, din};
      for (int k = 1; k < DEPTH; k++) begin
         stg_d[k] = stg_q[k-1];
      end
      stg_en              = {DEPTH{eff_adv}};
      stg_en[DEPTH-1]     = eff_adv & eff_out_en;
   end

   always_comb begin
      ovf_d = (ovf_q & ~ovf_clr)
            | (eff_adv & ~eff_out_en & vld[DEPTH-2]);
   end

   always_comb begin
      cnt = '0;
      for (int k = 0; k < DEPTH; k++) begin
         cnt = cnt + CW'(vld[k]);
      end
   end

   always_ff @(posedge clock0 or posedge rst1) begin
      if (rst1) begin
         state_q <= IDLE;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ovf_q   <= ovf_d;
      end
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      localparam int G = grp_of(k, DEPTH, NGRP);
      assign stg_clr[k] = rst1 | grp_rst[G];
      assign vld[k]     = stg_q[k][WIDTH];
      hop_stage #(.W(WIDTH + 1)) u_stg (
         .clock0 (clock0),
         .clr    (stg_clr[k]),
         .en     (stg_en[k]),
         .d      (stg_d[k]),
         .q      (stg_q[k])
      );
   end

   assign dout       = stg_q[DEPTH-1][WIDTH-1:0];
   assign dout_valid = vld[DEPTH-1];
   assign fill_cnt   = cnt;
   assign ovf        = ovf_q;
   assign busy       = (state_q == FLUSH);

endmodule

// File: tb/tb_hop_chain_pipe.sv
// Scoreboard bench for hop_chain_pipe (8-deep main DUT, 2-deep side DUT).
module tb_hop_chain_pipe;

   logic       clock0 = 1'b0;
   logic       rst1 = 1'b1;
   logic [5:0] grp_rst = '0;
   logic       g2 = 1'b0;
   logic [3:0] din = '0;
   logic       din_valid = 1'b0;
   logic       adv = 1'b0;
   logic       out_en = 1'b0;
   logic       flush = 1'b0;
   logic       ovf_clr = 1'b0;

   logic [3:0] dout;
   logic       dout_valid;
   logic [3:0] fill_cnt;
   logic       ovf;
   logic       busy;
   logic [3:0] dout2;
   logic       dout_valid2;
   logic [1:0] fill_cnt2;
   logic       ovf2;
   logic       busy2;

   int n_chk = 0;
   int n_fail = 0;
   logic [3:0] sb[$];
   logic [3:0] exp_v;

   hop_chain_pipe #(.WIDTH(4), .DEPTH(8), .NGRP(6)) dut (
      .clock0(clock0), .rst1(rst1), .grp_rst(grp_rst),
      .din(din), .din_valid(din_valid), .adv(adv),
      .out_en(out_en), .flush(flush), .ovf_clr(ovf_clr),
      .dout(dout), .dout_valid(dout_valid), .fill_cnt(fill_cnt),
      .ovf(ovf), .busy(busy)
   );

   hop_chain_pipe #(.WIDTH(4), .DEPTH(2), .NGRP(1)) dut2 (
      .clock0(clock0), .rst1(rst1), .grp_rst(g2),
      .din(din), .din_valid(din_valid), .adv(adv),
      .out_en(out_en), .flush(flush), .ovf_clr(ovf_clr),
      .dout(dout2), .dout_valid(dout_valid2), .fill_cnt(fill_cnt2),
      .ovf(ovf2), .busy(busy2)
   );

   always #5 clock0 = ~clock0;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock0);
      #1;
   endtask

   task automatic fill_chain();
      rst1 = 1'b1;
      #2;
      rst1 = 1'b0;
      sb.delete();
      flush = 1'b0; ovf_clr = 1'b0; grp_rst = '0;
      adv = 1'b1; out_en = 1'b1; din_valid = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         din = 4'(i);
         sb.push_back(4'(i));
         tick();
      end
      din_valid = 1'b0; din = '0; adv = 1'b0; out_en = 1'b0;
      n_chk++;
      if (fill_cnt !== 4'd8 || dout_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL fill: got cnt=%0d v=%b want cnt=8 v=1", fill_cnt, dout_valid);
      end
      exp_v = sb.pop_front();
      n_chk++;
      if (dout !== exp_v) begin
         n_fail++;
         $display("FAIL fill_head: got %0h want %0h", dout, exp_v);
      end
   endtask

   task automatic drain(input string nm);
      adv = 1'b1; out_en = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         if (dout_valid === 1'b1) begin
            n_chk++;
            if (sb.size() == 0) begin
               n_fail++;
               $display("FAIL %s_extra: got %0h want none", nm, dout);
            end else begin
               exp_v = sb.pop_front();
               if (dout !== exp_v) begin
                  n_fail++;
                  $display("FAIL %s_order: got %0h want %0h", nm, dout, exp_v);
               end
            end
         end
      end
      adv = 1'b0; out_en = 1'b0;
      n_chk++;
      if (sb.size() != 0 || fill_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL %s_end: got left=%0d cnt=%0d want 0 0", nm, sb.size(), fill_cnt);
      end
   endtask

   task automatic test_reset();
      #3;
      n_chk++;
      if ({dout, dout_valid, fill_cnt, ovf, busy} !== 11'd0) begin
         n_fail++;
         $display("FAIL reset: got d=%0h v=%b c=%0d o=%b b=%b want all 0",
                  dout, dout_valid, fill_cnt, ovf, busy);
      end
      #4;
      rst1 = 1'b0;
   endtask

   task automatic test_latency();
      sb.delete();
      adv = 1'b1; out_en = 1'b1; din = 4'd1; din_valid = 1'b1;
      sb.push_back(4'd1);
      tick();
      din = '0; din_valid = 1'b0;
      n_chk++;
      if (dout_valid2 !== 1'b0 || fill_cnt2 !== 2'd1) begin
         n_fail++;
         $display("FAIL lat2_e1: got v=%b c=%0d want 0 1", dout_valid2, fill_cnt2);
      end
      for (int e = 1; e <= 8; e++) begin
         if (e > 1) tick();
         if (e == 2) begin
            n_chk++;
            if (dout_valid2 !== 1'b1 || dout2 !== 4'd1) begin
               n_fail++;
               $display("FAIL lat2_out: got v=%b d=%0h want 1 1", dout_valid2, dout2);
            end
         end
         n_chk++;
         if (fill_cnt !== 4'd1 || dout_valid !== (e == 8)) begin
            n_fail++;
            $display("FAIL lat_e%0d: got c=%0d v=%b want c=1 v=%b",
                     e, fill_cnt, dout_valid, e == 8);
         end
      end
      if (dout_valid === 1'b1) begin
         exp_v = sb.pop_front();
         n_chk++;
         if (dout !== exp_v) begin
            n_fail++;
            $display("FAIL lat_dout: got %0h want %0h", dout, exp_v);
         end
      end
      tick();
      n_chk++;
      if (dout_valid !== 1'b0 || fill_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL lat_empty: got v=%b c=%0d want 0 0", dout_valid, fill_cnt);
      end
      adv = 1'b0; out_en = 1'b0;
   endtask

   task automatic test_overrun();
      fill_chain();
      adv = 1'b1; out_en = 1'b0;
      tick();
      void'(sb.pop_front());
      adv = 1'b0;
      n_chk++;
      if (ovf !== 1'b1 || dout !== 4'd1 || fill_cnt !== 4'd7) begin
         n_fail++;
         $display("FAIL ovf_set: got o=%b d=%0h c=%0d want 1 1 7", ovf, dout, fill_cnt);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      n_chk++;
      if (ovf !== 1'b0 || fill_cnt !== 4'd7) begin
         n_fail++;
         $display("FAIL ovf_clr: got o=%b c=%0d want 0 7", ovf, fill_cnt);
      end
      adv = 1'b1; out_en = 1'b0; ovf_clr = 1'b1;
      tick();
      void'(sb.pop_front());
      adv = 1'b0; ovf_clr = 1'b0;
      n_chk++;
      if (ovf !== 1'b1) begin
         n_fail++;
         $display("FAIL ovf_set_wins: got %b want 1", ovf);
      end
      ovf_clr = 1'b1;
      tick();
      ovf_clr = 1'b0;
      drain("ovf_drain");
      n_chk++;
      if (ovf !== 1'b0) begin
         n_fail++;
         $display("FAIL ovf_quiet: got %b want 0", ovf);
      end
   endtask

   task automatic test_grp_rst();
      fill_chain();
      grp_rst = 6'b001000;
      #1;
      n_chk++;
      if (fill_cnt !== 4'd6 || dout_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL grp_cnt: got c=%0d v=%b want 6 1", fill_cnt, dout_valid);
      end
      #1;
      grp_rst = '0;
      #1;
      n_chk++;
      if (fill_cnt !== 4'd6) begin
         n_fail++;
         $display("FAIL grp_hold: got %0d want 6", fill_cnt);
      end
      sb.delete(1);
      sb.delete(1);
      drain("grp_drain");
   endtask

   task automatic test_flush_full();
      fill_chain();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_chk++;
      if (busy !== 1'b1 || fill_cnt !== 4'd8 || dout !== 4'd1) begin
         n_fail++;
         $display("FAIL fl_start: got b=%b c=%0d d=%0h want 1 8 1", busy, fill_cnt, dout);
      end
      din = 4'hf; din_valid = 1'b1;
      for (int i = 1; i <= 9; i++) begin
         tick();
         n_chk++;
         if (busy !== (i <= 8) || fill_cnt !== 4'((i <= 8) ? 8 - i : 0)
             || dout_valid !== (i <= 7)) begin
            n_fail++;
            $display("FAIL fl_e%0d: got b=%b c=%0d v=%b want b=%b c=%0d v=%b",
                     i, busy, fill_cnt, dout_valid, i <= 8,
                     (i <= 8) ? 8 - i : 0, i <= 7);
         end
         if (dout_valid === 1'b1 && sb.size() > 0) begin
            exp_v = sb.pop_front();
            n_chk++;
            if (dout !== exp_v) begin
               n_fail++;
               $display("FAIL fl_order: got %0h want %0h", dout, exp_v);
            end
         end
      end
      din = '0; din_valid = 1'b0;
      n_chk++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL fl_left: got %0d want 0", sb.size());
      end
   endtask

   task automatic test_flush_empty();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      n_chk++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL fe_busy: got %b want 1", busy);
      end
      tick();
      n_chk++;
      if (busy !== 1'b0 || fill_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL fe_done: got b=%b c=%0d want 0 0", busy, fill_cnt);
      end
   endtask

   task automatic test_rst_mid_flush();
      fill_chain();
      sb.delete();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      tick();
      tick();
      #1;
      rst1 = 1'b1;
      #1;
      n_chk++;
      if ({dout, dout_valid, fill_cnt, ovf, busy} !== 11'd0) begin
         n_fail++;
         $display("FAIL rst_mid: got d=%0h v=%b c=%0d o=%b b=%b want all 0",
                  dout, dout_valid, fill_cnt, ovf, busy);
      end
      rst1 = 1'b0;
      tick();
      n_chk++;
      if (busy !== 1'b0 || fill_cnt !== 4'd0) begin
         n_fail++;
         $display("FAIL rst_idle: got b=%b c=%0d want 0 0", busy, fill_cnt);
      end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_overrun();
      test_grp_rst();
      test_flush_full();
      test_flush_empty();
      test_rst_mid_flush();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
